// File: rtl/riscv_core_pkg.sv
// Shared types and sizes for the core's stream steering blocks.
package riscv_core_pkg;
   localparam int DEMUX_LANES = 4;
   typedef logic [1:0] lane_sel_t;
   typedef logic [1:0] lane_cnt_t;
endpackage

// File: rtl/riscv_core_fifo2.sv
// Two-entry FIFO with flush: a push is visible at the head after one edge.
// A push is ignored when full and a pop is ignored when empty; flush or reset clears pointers and count, not storage.
module riscv_core_fifo2
   import riscv_core_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            push,
   input  logic [XLEN-1:0] wdata,
   input  logic            pop,
   output logic [XLEN-1:0] rdata,
   output logic            full,
   output logic            empty,
   output logic [1:0]      count
);

   logic [XLEN-1:0] mem [2];
   logic            wptr;
   logic            rptr;
   lane_cnt_t       cnt;
   logic            do_push;
   logic            do_pop;

   assign do_push = push & (cnt != 2'd2);
   assign do_pop  = pop & (cnt != 2'd0);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= 1'b0;
         rptr <= 1'b0;
         cnt  <= 2'd0;
      end else begin
         if (do_push) wptr <= ~wptr;
         if (do_pop)  rptr <= ~rptr;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is left uncleared; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign full  = (cnt == 2'd2);
   assign empty = (cnt == 2'd0);
   assign count = cnt;

endmodule

// File: rtl/riscv_core_demux1x4.sv
// Registered 1:4 stream demux, one 2-entry buffer per lane; one-edge latency, 1 word/cycle per lane.
// Input ready is the selected lane's registered not-full flag, so a stalled lane only blocks words routed to it.
module riscv_core_demux1x4
   import riscv_core_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_demux_flush,
   input  logic                                i_demux_valid,
   input  logic [XLEN-1:0]                     i_demux_data,
   input  logic [1:0]                          i_demux_sel,
   output logic                                o_demux_ready,
   output logic [DEMUX_LANES-1:0]              o_demux_valid,
   output logic [DEMUX_LANES-1:0][XLEN-1:0]    o_demux_data,
   input  logic [DEMUX_LANES-1:0]              i_demux_ready,
   output logic [DEMUX_LANES-1:0][1:0]         o_demux_count
);

   lane_sel_t              sel;
   logic [DEMUX_LANES-1:0] full;
   logic [DEMUX_LANES-1:0] empty;
   logic [DEMUX_LANES-1:0] push_vec;
   logic [DEMUX_LANES-1:0] pop_vec;

   assign sel = i_demux_sel;

   // No path from the consumers' ready to the producer's ready.
   assign o_demux_ready = ~full[sel] & ~i_demux_flush & ~i_rst;

   always_comb begin
      push_vec = '0;
      if (i_demux_valid && o_demux_ready) push_vec[sel] = 1'b1;
   end

   assign pop_vec = o_demux_valid & i_demux_ready;

   for (genvar k = 0; k < DEMUX_LANES; k++) begin : g_lane
      riscv_core_fifo2 #(.XLEN(XLEN)) u_fifo (
         .clk   (i_clk),
         .rst   (i_rst),
         .flush (i_demux_flush),
         .push  (push_vec[k]),
         .wdata (i_demux_data),
         .pop   (pop_vec[k]),
         .rdata (o_demux_data[k]),
         .full  (full[k]),
         .empty (empty[k]),
         .count (o_demux_count[k])
      );
      assign o_demux_valid[k] = ~empty[k];
   end

endmodule
